// File: rtl/pokey_timer_pair.sv
// pokey_timer_pair: two 8-bit down-counters that reload from their frequency
// registers. Each channel emits a one-cycle underflow pulse. In link mode the
// pair runs as one 16-bit counter, with A as the low byte and B as the high byte.
//
// Ports:
//   clk, sync_reset          clock and synchronous active-high reset
//   enable_a, enable_b       per-channel tick strobes (enable_b unused when linked)
//   link                     1 = chain A (low) and B (high) into a 16-bit counter
//   load                     reload both counters from freq_a / freq_b
//   freq_a, freq_b           reload values
//   count_a, count_b         current counts (registered)
//   underflow_a/b            one-cycle underflow pulses (registered)
module pokey_timer_pair (
   input  logic       clk,
   input  logic       sync_reset,
   input  logic       enable_a,
   input  logic       enable_b,
   input  logic       link,
   input  logic       load,
   input  logic [7:0] freq_a,
   input  logic [7:0] freq_b,
   output logic [7:0] count_a,
   output logic [7:0] count_b,
   output logic       underflow_a,
   output logic       underflow_b
);

   localparam int unsigned CW = 8;
   localparam int unsigned LW = 2 * CW;

   logic [CW-1:0] count_a_nxt;
   logic [CW-1:0] count_b_nxt;
   logic          underflow_a_nxt;
   logic          underflow_b_nxt;
   logic [LW-1:0] pair_dec;

   assign pair_dec = {count_b, count_a} - LW'(1);

   // Next-state selection: load beats tick; reset is applied in the register.
   always_comb begin
      count_a_nxt     = count_a;
      count_b_nxt     = count_b;
      underflow_a_nxt = 1'b0;
      underflow_b_nxt = 1'b0;
      if (load) begin
         count_a_nxt = freq_a;
         count_b_nxt = freq_b;
      end else if (link) begin
         // Joined mode: only enable_a advances the pair; B reports the underflow.
         if (enable_a) begin
            if ({count_b, count_a} == LW'(0)) begin
               count_a_nxt     = freq_a;
               count_b_nxt     = freq_b;
               underflow_b_nxt = 1'b1;
            end else begin
               count_a_nxt = pair_dec[CW-1:0];
               count_b_nxt = pair_dec[LW-1:CW];
            end
         end
      end else begin
         if (enable_a) begin
            if (count_a == CW'(0)) begin
               count_a_nxt     = freq_a;
               underflow_a_nxt = 1'b1;
            end else begin
               count_a_nxt = count_a - CW'(1);
            end
         end
         if (enable_b) begin
            if (count_b == CW'(0)) begin
               count_b_nxt     = freq_b;
               underflow_b_nxt = 1'b1;
            end else begin
               count_b_nxt = count_b - CW'(1);
            end
         end
      end
   end

   // State and output registers; reset suppresses any pending pulse.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         count_a     <= '0;
         count_b     <= '0;
         underflow_a <= 1'b0;
         underflow_b <= 1'b0;
      end else begin
         count_a     <= count_a_nxt;
         count_b     <= count_b_nxt;
         underflow_a <= underflow_a_nxt;
         underflow_b <= underflow_b_nxt;
      end
   end

endmodule

// File: tb/tb_pokey_timer_pair.sv
module tb_pokey_timer_pair;

   logic       clk = 1'b0;
   logic       sync_reset;
   logic       enable_a;
   logic       enable_b;
   logic       link;
   logic       load;
   logic [7:0] freq_a;
   logic [7:0] freq_b;
   logic [7:0] count_a;
   logic [7:0] count_b;
   logic       underflow_a;
   logic       underflow_b;

   int total = 0;
   int bad   = 0;

   pokey_timer_pair dut (
      .clk         (clk),
      .sync_reset  (sync_reset),
      .enable_a    (enable_a),
      .enable_b    (enable_b),
      .link        (link),
      .load        (load),
      .freq_a      (freq_a),
      .freq_b      (freq_b),
      .count_a     (count_a),
      .count_b     (count_b),
      .underflow_a (underflow_a),
      .underflow_b (underflow_b)
   );

   always #5 clk = ~clk;

   // Advance one clock and sample just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                          input logic ua, input logic ub);
      chk({tag, ".count_a"}, 16'(count_a), 16'(ea));
      chk({tag, ".count_b"}, 16'(count_b), 16'(eb));
      chk({tag, ".uf_a"}, 16'(underflow_a), 16'(ua));
      chk({tag, ".uf_b"}, 16'(underflow_b), 16'(ub));
   endtask

   initial begin
      logic [15:0] exp_pair;
      logic [15:0] prev;
      logic        exp_ub;
      int          pulses;
      int          pulse_at;

      sync_reset = 1'b1; enable_a = 1'b0; enable_b = 1'b0; link = 1'b0;
      load = 1'b0; freq_a = 8'h00; freq_b = 8'h00;
      step();
      chk_all("reset", 8'h00, 8'h00, 1'b0, 1'b0);

      // load during reset has no effect
      load = 1'b1; freq_a = 8'h05; freq_b = 8'h06;
      step();
      chk_all("load_in_reset", 8'h00, 8'h00, 1'b0, 1'b0);

      // reset then A counting with freq 3, enable held; load wins over tick
      sync_reset = 1'b0; load = 1'b1; freq_a = 8'h03; freq_b = 8'h00; enable_a = 1'b1;
      step();
      chk_all("a_load3", 8'h03, 8'h00, 1'b0, 1'b0);
      load = 1'b0;
      step(); chk_all("a_cnt2", 8'h02, 8'h00, 1'b0, 1'b0);
      step(); chk_all("a_cnt1", 8'h01, 8'h00, 1'b0, 1'b0);
      step(); chk_all("a_cnt0", 8'h00, 8'h00, 1'b0, 1'b0);
      step(); chk_all("a_reload", 8'h03, 8'h00, 1'b1, 1'b0);
      step(); chk_all("a_after", 8'h02, 8'h00, 1'b0, 1'b0);

      // freq write mid-count: 3 -> 7 while count_a = 2
      freq_a = 8'h07;
      step(); chk_all("fw_cnt1", 8'h01, 8'h00, 1'b0, 1'b0);
      step(); chk_all("fw_cnt0", 8'h00, 8'h00, 1'b0, 1'b0);
      step(); chk_all("fw_reload7", 8'h07, 8'h00, 1'b1, 1'b0);
      enable_a = 1'b0;
      step(); chk_all("fw_hold", 8'h07, 8'h00, 1'b0, 1'b0);

      // sparse ticks with freq 0
      load = 1'b1; freq_a = 8'h00;
      step(); chk_all("sp_load", 8'h00, 8'h00, 1'b0, 1'b0);
      load = 1'b0;
      for (int k = 0; k < 3; k++) begin
         enable_a = 1'b1;
         step(); chk_all("sp_tick", 8'h00, 8'h00, 1'b1, 1'b0);
         enable_a = 1'b0;
         step(); chk_all("sp_idle1", 8'h00, 8'h00, 1'b0, 1'b0);
         step(); chk_all("sp_idle2", 8'h00, 8'h00, 1'b0, 1'b0);
         step(); chk_all("sp_idle3", 8'h00, 8'h00, 1'b0, 1'b0);
      end

      // channel B independent, freq 2
      load = 1'b1; freq_b = 8'h02;
      step(); chk_all("b_load", 8'h00, 8'h02, 1'b0, 1'b0);
      load = 1'b0; enable_b = 1'b1;
      step(); chk_all("b_cnt1", 8'h00, 8'h01, 1'b0, 1'b0);
      step(); chk_all("b_cnt0", 8'h00, 8'h00, 1'b0, 1'b0);
      step(); chk_all("b_reload", 8'h00, 8'h02, 1'b0, 1'b1);
      enable_b = 1'b0;

      // load/tick collision
      load = 1'b1; freq_a = 8'h05;
      step(); chk_all("col_pre", 8'h05, 8'h02, 1'b0, 1'b0);
      freq_a = 8'h09; enable_a = 1'b1;
      step(); chk_all("col_load", 8'h09, 8'h02, 1'b0, 1'b0);
      load = 1'b0; enable_a = 1'b0;

      // back-to-back ticks, freq 0: underflow every cycle
      load = 1'b1; freq_a = 8'h00;
      step(); chk_all("b2b_load", 8'h00, 8'h02, 1'b0, 1'b0);
      load = 1'b0; enable_a = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(); chk_all("b2b", 8'h00, 8'h02, 1'b1, 1'b0);
      end

      // linked 16-bit, enable_b toggling must be ignored
      link = 1'b1; load = 1'b1; freq_b = 8'h01; freq_a = 8'h02; enable_a = 1'b1;
      step(); chk_all("lk_load", 8'h02, 8'h01, 1'b0, 1'b0);
      load = 1'b0;
      exp_pair = 16'h0102; pulses = 0; pulse_at = 0;
      for (int i = 1; i <= 262; i++) begin
         enable_b = i[0];
         prev = exp_pair;
         if (prev == 16'h0000) begin
            exp_pair = 16'h0102; exp_ub = 1'b1;
         end else begin
            exp_pair = prev - 16'h0001; exp_ub = 1'b0;
         end
         step();
         chk_all("lk", exp_pair[7:0], exp_pair[15:8], 1'b0, exp_ub);
         if (underflow_b) begin
            pulses++;
            pulse_at = i;
         end
      end
      chk("lk_pulses", 16'(pulses), 16'd1);
      chk("lk_period", 16'(pulse_at), 16'd259);

      // link change retains counts, no pulse; next tick is unlinked
      enable_a = 1'b0; enable_b = 1'b0;
      step(); chk_all("lk_hold", 8'hFF, 8'h00, 1'b0, 1'b0);
      link = 1'b0;
      step(); chk_all("unlink_hold", 8'hFF, 8'h00, 1'b0, 1'b0);
      enable_a = 1'b1;
      step(); chk_all("unlink_tick", 8'hFE, 8'h00, 1'b0, 1'b0);
      enable_a = 1'b0;

      // reset mid-count with a pending underflow on A
      load = 1'b1; freq_a = 8'h00; freq_b = 8'h40;
      step(); chk_all("rm_load", 8'h00, 8'h40, 1'b0, 1'b0);
      load = 1'b0; enable_a = 1'b1; sync_reset = 1'b1;
      step(); chk_all("rm_reset", 8'h00, 8'h00, 1'b0, 1'b0);
      sync_reset = 1'b0; enable_b = 1'b1;
      // after reset the first tick underflows immediately
      step(); chk_all("rm_first", 8'h00, 8'h40, 1'b1, 1'b1);
      enable_a = 1'b0; enable_b = 1'b0;
      step(); chk_all("rm_idle", 8'h00, 8'h40, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
